// File: rtl/conv_window_scheduler.sv
// Sliding-window address sequencer for one conv layer: walks every output
// pixel and streams its K*K input addresses and tap indices to the MAC.
module conv_window_scheduler #(
   parameter int IN_W   = 28,
   parameter int K      = 5,
   parameter int STRIDE = 1,
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 5,
   parameter int TAP_W  = 5
) (
   input  logic              clk,
   input  logic              global_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic [TAP_W-1:0]  o_kidx,
   output logic              o_win_last,
   output logic [CNT_W-1:0]  o_out_row,
   output logic [CNT_W-1:0]  o_out_col,
   output logic              o_busy,
   output logic              o_done
);

   localparam int OUT_W = (IN_W - K) / STRIDE + 1;
   localparam int AW    = ADDR_W + CNT_W;

   // One-hot so valid/done/busy come straight off flops.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t state, state_nx;

   logic [CNT_W-1:0] kx, ky, col, row;
   logic [CNT_W-1:0] kx_nx, ky_nx, col_nx, row_nx;
   logic [AW-1:0]    addr_nx;
   logic [TAP_W-1:0] kidx_nx;
   logic             win_nx;
   logic             kx_end, ky_end, col_end, row_end;
   logic             fire, last_beat;

   assign kx_end    = (kx == CNT_W'(K - 1));
   assign ky_end    = (ky == CNT_W'(K - 1));
   assign col_end   = (col == CNT_W'(OUT_W - 1));
   assign row_end   = (row == CNT_W'(OUT_W - 1));
   assign fire      = state[1] & i_ready & ~i_abort;
   assign last_beat = fire & kx_end & ky_end & col_end & row_end;

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (1'b1)
         state[0]: if (i_start) state_nx = RUN;
         state[1]: begin
            if (i_abort)        state_nx = IDLE;
            else if (last_beat) state_nx = DONE;
         end
         state[2]: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Tap counters advance innermost-first; abort and walk end clear them.
   always_comb begin
      kx_nx  = kx;
      ky_nx  = ky;
      col_nx = col;
      row_nx = row;
      if (!state[1] || i_abort || last_beat) begin
         kx_nx  = '0;
         ky_nx  = '0;
         col_nx = '0;
         row_nx = '0;
      end else if (fire) begin
         kx_nx = kx_end ? '0 : kx + 1'b1;
         if (kx_end) ky_nx = ky_end ? '0 : ky + 1'b1;
         if (kx_end && ky_end) begin
            col_nx = col_end ? '0 : col + 1'b1;
            if (col_end) row_nx = row_end ? '0 : row + 1'b1;
         end
      end
   end

   always_comb begin
      addr_nx = (AW'(row_nx) * AW'(STRIDE) + AW'(ky_nx)) * AW'(IN_W)
              + AW'(col_nx) * AW'(STRIDE) + AW'(kx_nx);
      kidx_nx = TAP_W'(ky_nx) * TAP_W'(K) + TAP_W'(kx_nx);
      win_nx  = (kx_nx == CNT_W'(K - 1)) && (ky_nx == CNT_W'(K - 1))
              && (state_nx == RUN);
   end

   always_ff @(posedge clk or posedge global_rst) begin
      if (global_rst) begin
         kx         <= '0;
         ky         <= '0;
         col        <= '0;
         row        <= '0;
         o_addr     <= '0;
         o_kidx     <= '0;
         o_win_last <= 1'b0;
      end else begin
         kx         <= kx_nx;
         ky         <= ky_nx;
         col        <= col_nx;
         row        <= row_nx;
         o_addr     <= addr_nx[ADDR_W-1:0];
         o_kidx     <= kidx_nx;
         o_win_last <= win_nx;
      end
   end

   assign o_valid   = state[1];
   assign o_done    = state[2];
   assign o_busy    = state[1] | state[2];
   assign o_out_row = row;
   assign o_out_col = col;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench: stride-1 and stride-2 instances, random ready,
// abort, restart, start-spam and async reset scenarios.
module tb_conv_window_scheduler;

   logic clk = 1'b0;
   logic global_rst = 1'b1;

   logic       a_start = 0, a_abort = 0, a_ready = 0;
   logic       a_valid, a_win_last, a_busy, a_done;
   logic [9:0] a_addr;
   logic [4:0] a_kidx, a_out_row, a_out_col;

   logic       b_start = 0, b_abort = 0, b_ready = 0;
   logic       b_valid, b_win_last, b_busy, b_done;
   logic [9:0] b_addr;
   logic [4:0] b_kidx, b_out_row, b_out_col;

   always #5 clk = ~clk;

   conv_window_scheduler #(
      .IN_W(6), .K(3), .STRIDE(1), .ADDR_W(10), .CNT_W(5), .TAP_W(5)
   ) dut_a (
      .clk(clk), .global_rst(global_rst),
      .i_start(a_start), .i_abort(a_abort), .i_ready(a_ready),
      .o_valid(a_valid), .o_addr(a_addr), .o_kidx(a_kidx),
      .o_win_last(a_win_last), .o_out_row(a_out_row),
      .o_out_col(a_out_col), .o_busy(a_busy), .o_done(a_done)
   );

   conv_window_scheduler #(
      .IN_W(7), .K(3), .STRIDE(2), .ADDR_W(10), .CNT_W(5), .TAP_W(5)
   ) dut_b (
      .clk(clk), .global_rst(global_rst),
      .i_start(b_start), .i_abort(b_abort), .i_ready(b_ready),
      .o_valid(b_valid), .o_addr(b_addr), .o_kidx(b_kidx),
      .o_win_last(b_win_last), .o_out_row(b_out_row),
      .o_out_col(b_out_col), .o_busy(b_busy), .o_done(b_done)
   );

   typedef struct packed {
      logic [9:0] addr;
      logic [4:0] kidx;
      logic [4:0] row;
      logic [4:0] col;
      logic       last;
   } beat_t;

   beat_t qa[$], qb[$];
   int vectors = 0, miscompares = 0;
   int cyc = 0;
   int acc_a = 0, acc_b = 0, done_a = 0, done_b = 0;
   int lastfire_a = -10, lastfire_b = -10;
   logic [9:0] last_addr_a = 0, last_addr_b = 0;
   beat_t cur_a, prev_a, cur_b, exp_beat;
   bit pv_a = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference walk built from the window geometry.
   task automatic push_walk(input bit to_b, input int in_w, input int k,
                            input int s, input int limit);
      int ow = (in_w - k) / s + 1;
      int n = 0;
      beat_t bt;
      for (int orow = 0; orow < ow; orow++)
         for (int ocol = 0; ocol < ow; ocol++)
            for (int ky = 0; ky < k; ky++)
               for (int kx = 0; kx < k; kx++)
                  if (n < limit) begin
                     bt.addr = 10'((orow * s + ky) * in_w + ocol * s + kx);
                     bt.kidx = 5'(ky * k + kx);
                     bt.row  = 5'(orow);
                     bt.col  = 5'(ocol);
                     bt.last = (ky == k - 1) && (kx == k - 1);
                     if (to_b) qb.push_back(bt);
                     else      qa.push_back(bt);
                     n++;
                  end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (global_rst) begin
         pv_a = 0;
      end else begin
         cur_a = {a_addr, a_kidx, a_out_row, a_out_col, a_win_last};
         if (pv_a) begin
            check("hold_valid_a", a_valid, 1);
            check("hold_beat_a", cur_a, prev_a);
         end
         if (a_valid && a_ready && !a_abort) begin
            if (qa.size() == 0) begin
               check("extra_beat_a", 1, 0);
            end else begin
               exp_beat = qa.pop_front();
               check("beat_a", cur_a, exp_beat);
            end
            acc_a++;
            lastfire_a = cyc;
            last_addr_a = a_addr;
         end
         if (a_done) begin
            done_a++;
            check("done_timing_a", cyc - lastfire_a, 1);
         end
         pv_a = a_valid && !a_ready && !a_abort;
         prev_a = cur_a;

         cur_b = {b_addr, b_kidx, b_out_row, b_out_col, b_win_last};
         if (b_valid && b_ready && !b_abort) begin
            if (qb.size() == 0) begin
               check("extra_beat_b", 1, 0);
            end else begin
               exp_beat = qb.pop_front();
               check("beat_b", cur_b, exp_beat);
            end
            acc_b++;
            lastfire_b = cyc;
            last_addr_b = b_addr;
         end
         if (b_done) begin
            done_b++;
            check("done_timing_b", cyc - lastfire_b, 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic walk_a(input bit rnd, input bit spam);
      int t = 0;
      int d0 = done_a;
      int a0 = acc_a;
      push_walk(0, 6, 3, 1, 1 << 30);
      a_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start = 1;
      tick();
      a_start = 0;
      check("start_valid", a_valid, 1);
      check("start_addr", a_addr, 0);
      check("start_kidx", a_kidx, 0);
      while (!a_done && t < 5000) begin
         a_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (spam) a_start = 1'($urandom_range(0, 1));
         tick();
         t++;
      end
      check("walk_timeout", t < 5000, 1);
      if (spam) a_start = 1;
      tick();
      a_start = 0;
      tick();
      check("idle_valid", a_valid, 0);
      check("idle_busy", a_busy, 0);
      check("beat_count", acc_a - a0, 144);
      check("last_addr", last_addr_a, 35);
      check("done_once", done_a - d0, 1);
      check("queue_empty", qa.size(), 0);
   endtask

   initial begin
      int t;
      int d0;
      int a0;
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int d0;
      int a0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", a_valid, 0);
      check("rst_addr", a_addr, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      global_rst = 0;
      tick();

      walk_a(0, 0);
      walk_a(1, 0);

      // abort after 50 accepted beats
      push_walk(0, 6, 3, 1, 50);
      d0 = done_a;
      a0 = acc_a;
      a_ready = 1;
      a_start = 1;
      tick();
      a_start = 0;
      t = 0;
      while (acc_a - a0 < 50 && t < 500) begin
         tick();
         t++;
      end
      check("abort_wait", t < 500, 1);
      a_abort = 1;
      tick();
      a_abort = 0;
      check("abort_valid", a_valid, 0);
      check("abort_busy", a_busy, 0);
      check("abort_addr", a_addr, 0);
      repeat (3) tick();
      check("abort_no_done", done_a - d0, 0);
      check("abort_beats", acc_a - a0, 50);
      check("abort_queue", qa.size(), 0);
      walk_a(0, 0);

      walk_a(0, 1);

      // async reset mid-walk
      push_walk(0, 6, 3, 1, 1 << 30);
      d0 = done_a;
      a_ready = 1;
      a_start = 1;
      tick();
      a_start = 0;
      repeat (30) tick();
      #2 global_rst = 1;
      #1;
      check("arst_valid", a_valid, 0);
      check("arst_addr", a_addr, 0);
      check("arst_kidx", a_kidx, 0);
      check("arst_row", a_out_row, 0);
      check("arst_col", a_out_col, 0);
      check("arst_last", a_win_last, 0);
      check("arst_busy", a_busy, 0);
      qa.delete();
      repeat (3) tick();
      global_rst = 0;
      tick();
      check("arst_no_done", done_a - d0, 0);
      walk_a(1, 0);

      // stride-2 instance
      push_walk(1, 7, 3, 2, 1 << 30);
      b_ready = 1;
      b_start = 1;
      tick();
      b_start = 0;
      check("b_start_addr", b_addr, 0);
      t = 0;
      while (!b_done && t < 5000) begin
         b_ready = ($urandom_range(0, 3) != 0);
         tick();
         t++;
      end
      check("b_timeout", t < 5000, 1);
      repeat (2) tick();
      check("b_beats", acc_b, 81);
      check("b_last_addr", last_addr_b, 48);
      check("b_done_once", done_b, 1);
      check("b_queue", qb.size(), 0);
      check("b_idle", b_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
